alu_mul_sequencer: RTL and testbench

Sequencing controller that sits in front of the shared 32-bit ripple ALU (Signal codes AND/OR/ADD/SUB/SLT). It accepts one operation at a time through a start/busy/done handshake. Single-pass ALU ops take one execute cycle. MULTU is a 32-iteration shift-add multiply that reuses the ALU's ADD path each cycle. The ALU itself is instantiated in the parent, and this block drives its operand and Signal inputs.

---
 rtl/alu_mul_sequencer_pkg.sv | 23 ++
 rtl/alu_mul_sequencer_if.sv | 23 ++
 rtl/alu_mul_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared codes for the ALU sequencer: ALU Signal encodings, the MULTU opcode
// and the controller state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_MULTU = 6'b011001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // True for operations the ALU completes in a single pass.
  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake between an issuing master and the sequencer.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [5:0]           op_in;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, op_in, src_a, src_b,
    input  busy, done, err, result
  );

  modport slave (
    input  start, op_in, src_a, src_b,
    output busy, done, err, result
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Sequencing controller in front of the shared ripple ALU: single-pass ops
// take one execute cycle, MULTU runs a WIDTH-iteration shift-add loop that
// borrows the ALU's ADD path every cycle.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_mul_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [5:0]           alu_signal,
  input  logic [WIDTH-1:0]     alu_result
);

  logic [1:0]         state_q,  state_d;
  logic [5:0]         op_q,     op_d;
  logic [WIDTH-1:0]   opa_q,    opa_d;
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q,    err_d;
  logic               carry;

  // Next-state, datapath updates and ALU operand steering.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    count_d    = count_q;
    result_d   = result_q;
    err_d      = err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_signal = OP_ADD;
    carry      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op_in;
          opa_d   = bus.src_a;
          opb_d   = bus.src_b;
          err_d   = 1'b0;
          count_d = '0;
          if (is_alu_op(bus.op_in)) begin
            state_d = ST_EXEC;
          end else if (bus.op_in == OP_MULTU) begin
            hi_d    = '0;
            lo_d    = bus.src_b;
            state_d = ST_MUL;
          end else begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_DONE;
          end
        end
      end

      ST_EXEC: begin
        alu_a      = opa_q;
        alu_b      = opb_q;
        alu_signal = op_q;
        result_d   = {{WIDTH{1'b0}}, alu_result};
        state_d    = ST_DONE;
      end

      ST_MUL: begin
        alu_a      = hi_q;
        alu_b      = lo_q[0] ? opa_q : '0;
        alu_signal = OP_ADD;
        // The ALU exposes no carry-out, so rebuild it from the operand and
        // sum MSBs.
        carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_result[WIDTH-1]);
        {hi_d, lo_d} = {carry, alu_result, lo_q[WIDTH-1:1]};
        count_d      = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          result_d = {hi_d, lo_d};
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = (state_q == ST_EXEC) || (state_q == ST_MUL);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU in the parent
// role.
module tb_alu_mul_sequencer;

  localparam logic [5:0] C_AND   = 6'b100100;
  localparam logic [5:0] C_OR    = 6'b100101;
  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_SUB   = 6'b100010;
  localparam logic [5:0] C_SLT   = 6'b101010;
  localparam logic [5:0] C_MULTU = 6'b011001;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_signal;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // Shared ALU as the parent datapath would provide it.
  always_comb begin
    case (alu_signal)
      C_AND:   alu_result = alu_a & alu_b;
      C_OR:    alu_result = alu_a | alu_b;
      C_ADD:   alu_result = alu_a + alu_b;
      C_SUB:   alu_result = alu_a - alu_b;
      C_SLT:   alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      C_AND:   return {32'd0, a & b};
      C_OR:    return {32'd0, a | b};
      C_ADD:   return {32'd0, a + b};
      C_SUB:   return {32'd0, a - b};
      C_SLT:   return {63'd0, $signed(a) < $signed(b)};
      C_MULTU: return {32'd0, a} * {32'd0, b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int unsigned ref_latency(input logic [5:0] op);
    case (op)
      C_AND, C_OR, C_ADD, C_SUB, C_SLT: return 2;
      C_MULTU:                          return 33;
      default:                          return 1;
    endcase
  endfunction

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'd0, bus.done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result, e.res);
        check("err", {63'd0, bus.err}, {63'd0, e.err});
        check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        check("busy_in_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  // Wait for IDLE, present one request for a single cycle, record expectation.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.op_in = op;
    bus.src_a = a;
    bus.src_b = b;
    e.res = ref_result(op, a, b);
    e.err = !(op == C_AND || op == C_OR || op == C_ADD || op == C_SUB ||
              op == C_SLT || op == C_MULTU);
    e.lat = ref_latency(op);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    ops[0] = C_AND; ops[1] = C_OR; ops[2] = C_ADD;
    ops[3] = C_SUB; ops[4] = C_SLT; ops[5] = C_MULTU;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_in = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {63'd0, bus.busy}, 64'd0);
    check("rst_done",   {63'd0, bus.done}, 64'd0);
    check("rst_err",    {63'd0, bus.err},  64'd0);
    check("rst_result", bus.result, 64'd0);
    check("idle_alu_a", {32'd0, alu_a}, 64'd0);
    check("idle_alu_sig", {58'd0, alu_signal}, {58'd0, C_ADD});
    reset = 1'b0;

    issue(C_ADD, 32'h5, 32'h7);
    check("add_busy", {63'd0, bus.busy}, 64'd1);
    issue(C_SUB, 32'h5, 32'h7);
    issue(C_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    issue(C_MULTU, 32'd3, 32'd5);
    issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(6'b000000, 32'h1234, 32'h5678);
    issue(C_ADD, 32'd1, 32'd2);
    issue(C_OR, 32'h0000FFFF, 32'h12340000);
    issue(C_SLT, 32'hFFFFFFFE, 32'd3);
    drain();

    @(negedge clk);
    check("idle_alu_b", {32'd0, alu_b}, 64'd0);

    // start held high throughout a multiply must not queue extra work
    issue(C_MULTU, 32'h00012345, 32'h00000010);
    bus.start = 1'b1;
    bus.op_in = C_ADD;
    bus.src_a = 32'hDEAD;
    bus.src_b = 32'hBEEF;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      check("hold_busy", {63'd0, bus.busy}, 64'd1);
    end
    bus.start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // reset in the middle of a multiply aborts it silently
    issue(C_MULTU, 32'hABCD, 32'h1234);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("abort_busy",   {63'd0, bus.busy}, 64'd0);
    check("abort_done",   {63'd0, bus.done}, 64'd0);
    check("abort_result", bus.result, 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(C_MULTU, 32'd2, 32'd2);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(ops[$urandom_range(0, 5)], $urandom, $urandom);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
